// File: rtl/vga_pkg.sv
// Shared types and default 640x480 timing for the VGA raster engine.
package vga_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_timing_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } vga_state_e;

  // Raster flags that travel with each request through the fetch latency.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
    logic vb;
  } vga_stage_t;

  localparam vga_timing_t VGA_H_640X480 = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
  localparam vga_timing_t VGA_V_640X480 = '{active: 16'd480, fp: 16'd10, sync: 16'd2, bp: 16'd33};

  function automatic int vga_total(vga_timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset to a chosen value.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: counters, look-ahead pixel fetch, and
// realignment of returned pixels with delayed sync/enable.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = int'(VGA_H_640X480.active),
  parameter int H_FP      = int'(VGA_H_640X480.fp),
  parameter int H_SYNC    = int'(VGA_H_640X480.sync),
  parameter int H_BP      = int'(VGA_H_640X480.bp),
  parameter int V_ACTIVE  = int'(VGA_V_640X480.active),
  parameter int V_FP      = int'(VGA_V_640X480.fp),
  parameter int V_SYNC    = int'(VGA_V_640X480.sync),
  parameter int V_BP      = int'(VGA_V_640X480.bp),
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int COLOR_W   = 4,
  parameter int FETCH_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  output logic                          pix_req_o,
  output logic [$clog2(H_ACTIVE)-1:0]   pix_x_o,
  output logic [$clog2(V_ACTIVE)-1:0]   pix_y_o,
  input  logic [3*COLOR_W-1:0]          pix_data_i,
  input  logic                          pix_valid_i,
  input  logic                          underflow_clr_i,
  output logic                          hs_o,
  output logic                          vs_o,
  output logic                          de_o,
  output logic [COLOR_W-1:0]            r_o,
  output logic [COLOR_W-1:0]            g_o,
  output logic [COLOR_W-1:0]            b_o,
  output logic                          frame_start_o,
  output logic                          vblank_o,
  output logic                          underflow_o
);

  localparam vga_timing_t H_TIM = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam vga_timing_t V_TIM = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam int H_TOTAL = vga_total(H_TIM);
  localparam int V_TOTAL = vga_total(V_TIM);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  vga_state_e          state_q, state_d;
  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  vga_stage_t          s0_q, s0_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  vga_stage_t          dly;
  logic                hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic                fs_q, fs_d, vb_q, vb_d, uf_q, uf_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                run_d;

  // Stage 0: raster counters and the request bundle for the next position
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            if (!en_i) state_d = ST_IDLE;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    run_d   = (state_d == ST_RUN);
    s0_d    = '0;
    s0_d.de = run_d && (h_d < H_ACT) && (v_d < V_ACT);
    s0_d.hs = run_d && (h_d >= HS_BEG) && (h_d < HS_END);
    s0_d.vs = run_d && (v_d >= VS_BEG) && (v_d < VS_END);
    s0_d.fs = run_d && (h_d == '0) && (v_d == '0);
    s0_d.vb = run_d && (v_d >= V_ACT);
    x_d     = s0_d.de ? XW'(h_d) : '0;
    y_d     = s0_d.de ? YW'(v_d) : '0;
  end

  // Stage 1..FETCH_LAT: flags wait for the framebuffer read to return
  vga_delay_line #(
    .WIDTH  ($bits(vga_stage_t)),
    .DEPTH  (FETCH_LAT),
    .RST_VAL('0)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .din_i (s0_q),
    .dout_o(dly)
  );

  // Output stage: merge returned pixel with delayed flags
  always_comb begin
    hs_d  = dly.hs ? HS_ACT : ~HS_ACT;
    vs_d  = dly.vs ? VS_ACT : ~VS_ACT;
    de_d  = dly.de;
    fs_d  = dly.fs;
    vb_d  = dly.vb;
    rgb_d = (dly.de && pix_valid_i) ? pix_data_i : '0;
    uf_d  = uf_q;
    if (underflow_clr_i) uf_d = 1'b0;
    if (dly.de && !pix_valid_i) uf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      s0_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= ~HS_ACT;
      vs_q    <= ~VS_ACT;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      vb_q    <= 1'b0;
      uf_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      s0_q    <= s0_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      vb_q    <= vb_d;
      uf_q    <= uf_d;
      rgb_q   <= rgb_d;
    end
  end

  assign pix_req_o     = s0_q.de;
  assign pix_x_o       = x_q;
  assign pix_y_o       = y_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;
  assign vblank_o      = vb_q;
  assign underflow_o   = uf_q;
  assign r_o           = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign g_o           = rgb_q[2*COLOR_W-1:COLOR_W];
  assign b_o           = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small 14x7 raster (two latency/polarity variants)
// and the default 640x480 timing, checked cycle by cycle against a timeline.
module tb_vga_timing_gen;

  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, valid;
  logic en_a, en_b, en_c;
  logic [3*CW-1:0] data;

  logic a_req, a_hs, a_vs, a_de, a_fs, a_vb, a_uf;
  logic [2:0] a_x;
  logic [1:0] a_y;
  logic [CW-1:0] a_r, a_g, a_b;
  logic b_req, b_hs, b_vs, b_de, b_fs, b_vb, b_uf;
  logic [2:0] b_x;
  logic [1:0] b_y;
  logic [CW-1:0] b_r, b_g, b_b;
  logic c_req, c_hs, c_vs, c_de, c_fs, c_vb, c_uf;
  logic [9:0] c_x;
  logic [8:0] c_y;
  logic [CW-1:0] c_r, c_g, c_b;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .COLOR_W(CW), .FETCH_LAT(2)
  ) u_a (
    .clk(clk), .rst(rst), .en_i(en_a), .pix_req_o(a_req), .pix_x_o(a_x), .pix_y_o(a_y),
    .pix_data_i(data), .pix_valid_i(valid), .underflow_clr_i(clr),
    .hs_o(a_hs), .vs_o(a_vs), .de_o(a_de), .r_o(a_r), .g_o(a_g), .b_o(a_b),
    .frame_start_o(a_fs), .vblank_o(a_vb), .underflow_o(a_uf)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .COLOR_W(CW), .FETCH_LAT(1)
  ) u_b (
    .clk(clk), .rst(rst), .en_i(en_b), .pix_req_o(b_req), .pix_x_o(b_x), .pix_y_o(b_y),
    .pix_data_i(data), .pix_valid_i(valid), .underflow_clr_i(clr),
    .hs_o(b_hs), .vs_o(b_vs), .de_o(b_de), .r_o(b_r), .g_o(b_g), .b_o(b_b),
    .frame_start_o(b_fs), .vblank_o(b_vb), .underflow_o(b_uf)
  );

  vga_timing_gen u_c (
    .clk(clk), .rst(rst), .en_i(en_c), .pix_req_o(c_req), .pix_x_o(c_x), .pix_y_o(c_y),
    .pix_data_i(data), .pix_valid_i(valid), .underflow_clr_i(clr),
    .hs_o(c_hs), .vs_o(c_vs), .de_o(c_de), .r_o(c_r), .g_o(c_g), .b_o(c_b),
    .frame_start_o(c_fs), .vblank_o(c_vb), .underflow_o(c_uf)
  );

  int   sel, lat, stop_n, dis_t;
  int   ha, hf, hsn, hb, va, vf, vsn, vbk;
  logic pol, ufx;
  int   n_chk, n_pass;

  logic [19:0] req_obs;
  logic [17:0] pin_obs;

  always_comb begin
    req_obs = '0;
    pin_obs = '0;
    case (sel)
      0: begin
        req_obs = {a_req, 10'(a_x), 9'(a_y)};
        pin_obs = {a_hs, a_vs, a_de, a_fs, a_vb, a_uf, a_r, a_g, a_b};
      end
      1: begin
        req_obs = {b_req, 10'(b_x), 9'(b_y)};
        pin_obs = {b_hs, b_vs, b_de, b_fs, b_vb, b_uf, b_r, b_g, b_b};
      end
      default: begin
        req_obs = {c_req, c_x, c_y};
        pin_obs = {c_hs, c_vs, c_de, c_fs, c_vb, c_uf, c_r, c_g, c_b};
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cfg(input int h0, input int h1, input int h2, input int h3,
                     input int v0, input int v1, input int v2, input int v3,
                     input int l, input logic p);
    ha = h0; hf = h1; hsn = h2; hb = h3;
    va = v0; vf = v1; vsn = v2; vbk = v3;
    lat = l; pol = p;
  endtask

  function automatic logic is_drop(int n);
    return ufx && (n == 115 || n == 213);
  endfunction

  function automatic logic is_clr(int n);
    return ufx && (n == 150 || n == 213);
  endfunction

  function automatic logic stage_de(int n);
    int ht, h, v;
    ht = ha + hf + hsn + hb;
    if (n < 0 || n >= stop_n) return 1'b0;
    h = n % ht;
    v = (n / ht) % (va + vf + vsn + vbk);
    return (h < ha) && (v < va);
  endfunction

  function automatic logic [11:0] pattern(int n);
    int ht, h, v;
    ht = ha + hf + hsn + hb;
    h = n % ht;
    v = (n / ht) % (va + vf + vsn + vbk);
    return {4'(h), 4'(v), 4'hF};
  endfunction

  function automatic logic [19:0] exp_req(int t);
    int ht, h, v;
    ht = ha + hf + hsn + hb;
    if (!stage_de(t)) return '0;
    h = t % ht;
    v = (t / ht) % (va + vf + vsn + vbk);
    return {1'b1, 10'(h), 9'(v)};
  endfunction

  function automatic logic [17:0] exp_pins(int n, logic uf);
    int ht, h, v;
    logic hs_a, vs_a, de, fs, vb;
    logic [11:0] rgb;
    ht = ha + hf + hsn + hb;
    hs_a = 1'b0; vs_a = 1'b0; de = 1'b0; fs = 1'b0; vb = 1'b0; rgb = '0;
    if (n >= 0 && n < stop_n) begin
      h    = n % ht;
      v    = (n / ht) % (va + vf + vsn + vbk);
      de   = (h < ha) && (v < va);
      hs_a = (h >= ha + hf) && (h < ha + hf + hsn);
      vs_a = (v >= va + vf) && (v < va + vf + vsn);
      fs   = (h == 0) && (v == 0);
      vb   = (v >= va);
      if (de && !is_drop(n)) rgb = pattern(n);
    end
    return {hs_a ? pol : ~pol, vs_a ? pol : ~pol, de, fs, vb, uf, rgb};
  endfunction

  task automatic set_en(input int s, input logic v);
    case (s)
      0: en_a = v;
      1: en_b = v;
      default: en_c = v;
    endcase
  endtask

  task automatic check_reset(input int s, input logic p, input string tag);
    sel = s;
    #1;
    check({tag, " req"}, 32'(req_obs), 32'd0);
    check({tag, " pins"}, 32'(pin_obs), 32'({~p, ~p, 16'd0}));
  endtask

  // Enable must already be high; the next edge is raster time t=0.
  task automatic run(input int s, input int ncyc, input int stop_i, input logic uf0);
    logic uf_m, uf_n, de_s;
    int ns;
    sel = s;
    stop_n = stop_i;
    uf_m = uf0;
    uf_n = uf0;
    data = '0;
    valid = 1'b1;
    clr = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk);
      #1;
      uf_m = uf_n;
      check($sformatf("req s%0d t=%0d", s, t), 32'(req_obs), 32'(exp_req(t)));
      check($sformatf("pins s%0d t=%0d", s, t), 32'(pin_obs), 32'(exp_pins(t - lat - 1, uf_m)));
      if (t == dis_t) set_en(s, 1'b0);
      ns    = t - lat;
      data  = (ns >= 0) ? pattern(ns) : '0;
      valid = !is_drop(ns);
      clr   = is_clr(ns);
      de_s  = stage_de(ns);
      uf_n  = (de_s && !valid) ? 1'b1 : (clr ? 1'b0 : uf_m);
    end
    clr = 1'b0;
    valid = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; clr = 1'b0; valid = 1'b1; data = '0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    sel = 0; dis_t = -1; ufx = 1'b0; stop_n = 0;
    cfg(8, 2, 3, 1, 4, 1, 1, 1, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset(0, 1'b0, "rst_a");
    check_reset(1, 1'b1, "rst_b");
    check_reset(2, 1'b0, "rst_c");

    // Four frames: underflow in frames 1 and 2, disable requested on line 2 of frame 3
    rst = 1'b0;
    en_a = 1'b1;
    ufx = 1'b1;
    dis_t = 3 * 98 + 28;
    run(0, 402, 392, 1'b0);
    @(posedge clk);
    #1;
    check("uf_idle", 32'(a_uf), 32'd1);
    check("req_idle", 32'(a_req), 32'd0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("uf_clr", 32'(a_uf), 32'd0);

    // Reset in the middle of a visible line, then restart cleanly
    ufx = 1'b0;
    dis_t = -1;
    en_a = 1'b1;
    run(0, 37, 1 << 30, 1'b0);
    check("de_before_rst", 32'(a_de), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset(0, 1'b0, "rst_mid");
    rst = 1'b0;
    run(0, 20, 1 << 30, 1'b0);
    en_a = 1'b0;

    // Inverted syncs with single-cycle fetch latency
    cfg(8, 2, 3, 1, 4, 1, 1, 1, 1, 1'b1);
    en_b = 1'b1;
    run(1, 110, 1 << 30, 1'b0);
    en_b = 1'b0;

    // Default 640x480 timing, first two lines and a bit
    cfg(640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0);
    en_c = 1'b1;
    run(2, 1700, 1 << 30, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
